// File: rtl/rx_tick_fifo.sv
// rx_tick_fifo
// Receive-path helper for the UART receiver: a baud-tick clock divider plus a
// byte FIFO with edge-triggered push/pop strobes.
//
// Ports:
//   i_clock    system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   o_clock    divided square-wave clock (registered)
//   i_write    push request, rising edge pushes i_wdata
//   i_wdata    push data
//   i_read     pop request, rising edge pops into o_rdata
//   o_rdata    last popped word, held until the next accepted pop
//   o_empty    FIFO holds no entries
//   o_full     FIFO holds DEPTH entries
//   o_count    current occupancy
module rx_tick_fifo #(
  parameter int CLOCK_RATE  = 50000000,
  parameter int OUTPUT_RATE = 153600,
  parameter int DEPTH       = 32,
  parameter int WIDTH       = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  output logic                     o_clock,
  input  logic                     i_write,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_read,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int HALF_RAW = CLOCK_RATE / (2 * OUTPUT_RATE);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             clk_q, clk_d;
  logic             w_q, r_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push_evt, pop_evt, push_ok, pop_ok, full;

  // Divider: counter runs 0..HALF-1, o_clock toggles on the wrap.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    clk_d = clk_q;
    if (div_q == DIV_W'(HALF - 1)) begin
      div_d = '0;
      clk_d = ~clk_q;
    end
  end

  // A pop accepted in the same cycle frees the slot a full-FIFO push needs;
  // the pop reads the old head before the write lands, so ordering holds.
  always_comb begin
    push_evt = i_write & ~w_q;
    pop_evt  = i_read  & ~r_q;
    full     = (count_q == CW'(DEPTH));
    pop_ok   = pop_evt & (count_q != '0);
    push_ok  = push_evt & (~full | pop_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;

    if (pop_ok) begin
      rdata_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q    <= '0;
      clk_q    <= 1'b0;
      w_q      <= 1'b0;
      r_q      <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      div_q    <= div_d;
      clk_q    <= clk_d;
      w_q      <= i_write;
      r_q      <= i_read;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage carries no reset.
  always_ff @(posedge i_clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  assign o_clock = clk_q;
  assign o_rdata = rdata_q;
  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = full;

endmodule

// File: tb/tb_rx_tick_fifo.sv
module tb_rx_tick_fifo;

  localparam int DEPTH = 32;
  localparam int WIDTH = 8;
  localparam int HALF  = 162;

  logic             i_clock = 1'b0;
  logic             i_reset_n = 1'b0;
  logic             o_clock;
  logic             i_write = 1'b0;
  logic [WIDTH-1:0] i_wdata = '0;
  logic             i_read = 1'b0;
  logic [WIDTH-1:0] o_rdata;
  logic             o_empty;
  logic             o_full;
  logic [5:0]       o_count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] last_rdata = '0;

  rx_tick_fifo #(
    .CLOCK_RATE (50000000),
    .OUTPUT_RATE(153600),
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH)
  ) dut (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .o_clock  (o_clock),
    .i_write  (i_write),
    .i_wdata  (i_wdata),
    .i_read   (i_read),
    .o_rdata  (o_rdata),
    .o_empty  (o_empty),
    .o_full   (o_full),
    .o_count  (o_count)
  );

  always #5 i_clock = ~i_clock;

  // Drivers: called at a negedge, return at a negedge. The scoreboard is
  // updated as stimulus is applied; strobes are high across one rising edge.
  task automatic drive_push(input logic [WIDTH-1:0] d);
    i_write = 1'b1;
    i_wdata = d;
    if (sb.size() < DEPTH) sb.push_back(d);
    @(negedge i_clock);
    i_write = 1'b0;
    @(negedge i_clock);
  endtask

  task automatic drive_pop();
    i_read = 1'b1;
    if (sb.size() > 0) last_rdata = sb.pop_front();
    @(negedge i_clock);
    i_read = 1'b0;
    @(negedge i_clock);
  endtask

  task automatic test_reset();
    int n;
    i_reset_n = 1'b0;
    @(negedge i_clock);
    checks++;
    if (o_empty !== 1'b1 || o_full !== 1'b0 || o_count !== 6'd0 || o_rdata !== 8'h00 || o_clock !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: empty=%b full=%b count=%0d rdata=%h oclk=%b, want 1 0 0 00 0",
               o_empty, o_full, o_count, o_rdata, o_clock);
    end
    i_reset_n = 1'b1;
    // First rise of o_clock, then fall, then rise, each HALF edges apart.
    for (int phase = 0; phase < 3; phase++) begin
      logic want;
      want = (phase == 1) ? 1'b0 : 1'b1;
      n = 0;
      while (n < 1000) begin
        @(posedge i_clock);
        n++;
        #1;
        if (o_clock === want) break;
      end
      checks++;
      if (n !== HALF) begin
        errors++;
        $display("FAIL divider_phase%0d: edges=%0d want %0d", phase, n, HALF);
      end
    end
    @(negedge i_clock);
  endtask

  task automatic test_held_strobe();
    i_write = 1'b1;
    i_wdata = 8'h41;
    sb.push_back(8'h41);
    repeat (300) @(negedge i_clock);
    i_write = 1'b0;
    @(negedge i_clock);
    checks++;
    if (o_count !== 6'd1 || o_empty !== 1'b0) begin
      errors++;
      $display("FAIL held_write: count=%0d empty=%b want 1 0", o_count, o_empty);
    end
    i_read = 1'b1;
    last_rdata = sb.pop_front();
    @(negedge i_clock);
    checks++;
    if (o_rdata !== last_rdata || o_count !== 6'd0 || o_empty !== 1'b1) begin
      errors++;
      $display("FAIL held_read: rdata=%h count=%0d empty=%b want %h 0 1",
               o_rdata, o_count, o_empty, last_rdata);
    end
    repeat (9) @(negedge i_clock);
    i_read = 1'b0;
    @(negedge i_clock);
    checks++;
    if (o_rdata !== last_rdata || o_count !== 6'd0) begin
      errors++;
      $display("FAIL held_read_after: rdata=%h count=%0d want %h 0", o_rdata, o_count, last_rdata);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) drive_push(8'(i));
    checks++;
    if (o_full !== 1'b1 || o_count !== 6'd32) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d want 1 32", o_full, o_count);
    end
    drive_push(8'hFF);
    checks++;
    if (o_full !== 1'b1 || o_count !== 6'd32) begin
      errors++;
      $display("FAIL overflow_drop: full=%b count=%0d want 1 32", o_full, o_count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive_pop();
      checks++;
      if (o_rdata !== last_rdata || o_count !== 6'(DEPTH - 1 - i)) begin
        errors++;
        $display("FAIL drain[%0d]: rdata=%h count=%0d want %h %0d",
                 i, o_rdata, o_count, last_rdata, DEPTH - 1 - i);
      end
    end
    checks++;
    if (o_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: empty=%b want 1", o_empty);
    end
  endtask

  task automatic test_pop_empty();
    drive_pop();
    checks++;
    if (o_rdata !== last_rdata || o_count !== 6'd0 || o_empty !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty: rdata=%h count=%0d empty=%b want %h 0 1",
               o_rdata, o_count, o_empty, last_rdata);
    end
    // Pop on empty with a simultaneous push: push lands, pop ignored.
    i_write = 1'b1;
    i_read  = 1'b1;
    i_wdata = 8'h5A;
    sb.push_back(8'h5A);
    @(negedge i_clock);
    i_write = 1'b0;
    i_read  = 1'b0;
    @(negedge i_clock);
    checks++;
    if (o_rdata !== last_rdata || o_count !== 6'd1) begin
      errors++;
      $display("FAIL pop_empty_with_push: rdata=%h count=%0d want %h 1", o_rdata, o_count, last_rdata);
    end
    drive_pop();
    checks++;
    if (o_rdata !== last_rdata || o_count !== 6'd0) begin
      errors++;
      $display("FAIL pop_after_push: rdata=%h count=%0d want %h 0", o_rdata, o_count, last_rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) drive_push(8'(8'h80 + i));
    i_write = 1'b1;
    i_read  = 1'b1;
    i_wdata = 8'hAA;
    last_rdata = sb.pop_front();
    sb.push_back(8'hAA);
    @(negedge i_clock);
    i_write = 1'b0;
    i_read  = 1'b0;
    @(negedge i_clock);
    checks++;
    if (o_rdata !== last_rdata || o_count !== 6'd32 || o_full !== 1'b1) begin
      errors++;
      $display("FAIL full_push_pop: rdata=%h count=%0d full=%b want %h 32 1",
               o_rdata, o_count, o_full, last_rdata);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive_pop();
      checks++;
      if (o_rdata !== last_rdata) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: rdata=%h want %h", i, o_rdata, last_rdata);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive_push(8'(8'h30 + i));
    checks++;
    if (o_count !== 6'd5) begin
      errors++;
      $display("FAIL pre_reset_count: count=%0d want 5", o_count);
    end
    @(posedge i_clock);
    #2;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_count !== 6'd0 || o_empty !== 1'b1 || o_clock !== 1'b0 || o_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d empty=%b oclk=%b full=%b want 0 1 0 0",
               o_count, o_empty, o_clock, o_full);
    end
    sb.delete();
    last_rdata = '0;
    @(negedge i_clock);
    i_reset_n = 1'b1;
    @(negedge i_clock);
    drive_pop();
    checks++;
    if (o_rdata !== 8'h00 || o_count !== 6'd0) begin
      errors++;
      $display("FAIL post_reset_pop: rdata=%h count=%0d want 00 0", o_rdata, o_count);
    end
  endtask

  initial begin
    test_reset();
    test_held_strobe();
    test_fill_drain();
    test_pop_empty();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
